// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: decodes a MIPS word into ALU op and operands,
// and buffers issued entries in an output register plus a skid register.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              ill;
  } entry_t;

  // Unknown opcodes and R-type functs still issue as ADD rs,rt but are flagged illegal.
  function automatic entry_t decode(input logic [31:0] instr,
                                    input logic [DATA_W-1:0] rs,
                                    input logic [DATA_W-1:0] rt);
    entry_t            e;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    sext  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    zext  = {{(DATA_W-16){1'b0}}, instr[15:0]};
    e.op  = ALU_ADD;
    e.a   = rs;
    e.b   = rt;
    e.ill = 1'b0;
    case (instr[31:26])
      6'b000000: begin
        case (instr[5:0])
          6'b100000: e.op = ALU_ADD;
          6'b100010: e.op = ALU_SUB;
          6'b100100: e.op = ALU_AND;
          6'b100101: e.op = ALU_OR;
          6'b100110: e.op = ALU_XOR;
          6'b100111: e.op = ALU_NOR;
          6'b101010: e.op = ALU_SLT;
          default:   e.ill = 1'b1;
        endcase
      end
      6'b001000, 6'b100011, 6'b101011: e.b = sext;
      6'b001010: begin e.op = ALU_SLT; e.b = sext; end
      6'b001100: begin e.op = ALU_AND; e.b = zext; end
      6'b001101: begin e.op = ALU_OR;  e.b = zext; end
      6'b001110: begin e.op = ALU_XOR; e.b = zext; end
      6'b000100: e.op = ALU_SUB;
      default:   e.ill = 1'b1;
    endcase
    return e;
  endfunction

  state_t state_r, state_s;
  entry_t or_r, sk_r, dec_s;
  logic   in_fire_s, out_fire_s;
  logic   load_or_s, load_sk_s, or_from_sk_s;
  logic   unused_instr_s;
  logic [CNT_W-1:0] cnt_r;

  assign unused_instr_s = ^in_instr[25:16];
  assign dec_s          = decode(in_instr, in_rs_val, in_rt_val);
  assign in_ready       = (state_r != ST_FULL);
  assign out_valid      = (state_r != ST_EMPTY);
  assign in_fire_s      = in_valid & in_ready;
  assign out_fire_s     = out_valid & out_ready;
  assign out_op         = or_r.op;
  assign out_a          = or_r.a;
  assign out_b          = or_r.b;
  assign out_illegal    = or_r.ill;
  assign illegal_count  = cnt_r;

  // Next-state and register load selection for the OR/SK pair.
  always_comb begin
    state_s      = state_r;
    load_or_s    = 1'b0;
    load_sk_s    = 1'b0;
    or_from_sk_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          load_or_s = 1'b1;
          state_s   = ST_ONE;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_fire_s && out_fire_s) begin
          load_or_s = 1'b1;
          state_s   = ST_ONE;
        end else if (in_fire_s) begin
          load_sk_s = 1'b1;
          state_s   = ST_FULL;
        end else if (out_fire_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_fire_s) begin
          or_from_sk_s = 1'b1;
          state_s      = ST_ONE;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State, entry storage and saturating illegal counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_EMPTY;
      or_r    <= '0;
      sk_r    <= '0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (load_or_s) begin
        or_r <= dec_s;
      end else if (or_from_sk_s) begin
        or_r <= sk_r;
      end
      if (load_sk_s) begin
        sk_r <= dec_s;
      end
      if (in_fire_s && dec_s.ill && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a queue-based reference model
// that decodes instructions from the ISA tables.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_illegal;
  logic [7:0]  illegal_count;

  int errors = 0;
  int checks = 0;
  bit last_in_fire = 1'b0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   exp_cnt = 0;

  alu_issue_stage #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    int unsigned imm;
    int unsigned opc;
    int unsigned fn;
    imm = ins & 32'h0000FFFF;
    opc = ins >> 26;
    fn  = ins & 32'h0000003F;
    e.op = 4'd0; e.a = rs; e.b = rt; e.ill = 1'b0;
    if (opc == 0) begin
      if      (fn == 32'h20) e.op = 4'd0;
      else if (fn == 32'h22) e.op = 4'd2;
      else if (fn == 32'h24) e.op = 4'd4;
      else if (fn == 32'h25) e.op = 4'd5;
      else if (fn == 32'h26) e.op = 4'd6;
      else if (fn == 32'h27) e.op = 4'd7;
      else if (fn == 32'h2A) e.op = 4'd10;
      else e.ill = 1'b1;
    end else if (opc == 32'h08 || opc == 32'h23 || opc == 32'h2B || opc == 32'h0A) begin
      e.op = (opc == 32'h0A) ? 4'd10 : 4'd0;
      e.b  = (imm >= 32'h8000) ? imm + 32'hFFFF0000 : imm;
    end else if (opc == 32'h0C || opc == 32'h0D || opc == 32'h0E) begin
      e.op = (opc == 32'h0C) ? 4'd4 : (opc == 32'h0D) ? 4'd5 : 4'd6;
      e.b  = imm;
    end else if (opc == 32'h04) begin
      e.op = 4'd2;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  opc;
    logic [5:0]  fn;
    w = $urandom;
    case ($urandom_range(0, 10))
      0, 1:    opc = 6'h00;
      2:       opc = 6'h08;
      3:       opc = 6'h0A;
      4:       opc = 6'h23;
      5:       opc = 6'h2B;
      6:       opc = 6'h0C;
      7:       opc = 6'h0D;
      8:       opc = 6'h0E;
      9:       opc = 6'h04;
      default: opc = 6'($urandom);
    endcase
    case ($urandom_range(0, 7))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h26;
      5: fn = 6'h27;
      6: fn = 6'h2A;
      default: fn = 6'($urandom);
    endcase
    return {opc, w[25:6], fn};
  endfunction

  // One clock: compare outputs to the model at negedge, then advance the model.
  task automatic cycle();
    bit   in_f;
    bit   out_f;
    exp_t e;
    @(negedge clk);
    check_eq("in_ready", in_ready, q.size() < 2);
    check_eq("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("out_op", out_op, q[0].op);
      check_eq("out_a", out_a, q[0].a);
      check_eq("out_b", out_b, q[0].b);
      check_eq("out_illegal", out_illegal, q[0].ill);
    end
    check_eq("illegal_count", illegal_count, exp_cnt);
    in_f  = in_valid && (q.size() < 2);
    out_f = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (out_f) void'(q.pop_front());
    if (in_f) begin
      e = ref_decode(in_instr, in_rs_val, in_rt_val);
      q.push_back(e);
      if (e.ill && exp_cnt < 255) exp_cnt++;
    end
    last_in_fire = in_f;
    #1;
  endtask

  task automatic send(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic ordy);
    in_valid = v; in_instr = ins; in_rs_val = rs; in_rt_val = rt; out_ready = ordy;
    cycle();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_rs_val = 32'd0;
    in_rt_val = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_op", out_op, 4'd0);
    check_eq("rst_out_a", out_a, 32'd0);
    check_eq("rst_out_b", out_b, 32'd0);
    check_eq("rst_out_illegal", out_illegal, 1'b0);
    check_eq("rst_count", illegal_count, 8'd0);
    reset = 1'b0;

    // R-type add
    send(1'b1, 32'h012A4020, 32'd5, 32'd7, 1'b1);
    check_eq("radd_valid", out_valid, 1'b1);
    check_eq("radd_op", out_op, 4'b0000);
    check_eq("radd_a", out_a, 32'd5);
    check_eq("radd_b", out_b, 32'd7);

    // Immediate sign/zero extension
    send(1'b1, {6'b001000, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd0, 1'b1);
    check_eq("addi_op", out_op, 4'b0000);
    check_eq("addi_b", out_b, 32'hFFFFFFFF);
    send(1'b1, {6'b001101, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd0, 1'b1);
    check_eq("ori_op", out_op, 4'b0101);
    check_eq("ori_b", out_b, 32'h0000FFFF);
    send(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

    // Back-pressure fills the skid register
    send(1'b1, {6'b001000, 5'd1, 5'd2, 16'h0003}, 32'd11, 32'd0, 1'b0);
    send(1'b1, {6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'b100010}, 32'd20, 32'd6, 1'b0);
    check_eq("bp_in_ready_low", in_ready, 1'b0);
    send(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    send(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    check_eq("bp_in_ready_back", in_ready, 1'b1);

    // Back-to-back stream
    for (int i = 0; i < 10; i++)
      send(1'b1, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100100}, 32'(i * 3), 32'(i + 100), 1'b1);
    send(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

    // Illegal-count saturation
    for (int i = 0; i < 300; i++)
      send(1'b1, {6'b111111, 26'($urandom)}, $urandom, $urandom, 1'b1);
    send(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    check_eq("sat_count", illegal_count, 8'd255);

    // Async reset while FULL
    send(1'b1, 32'h012A4020, 32'd1, 32'd2, 1'b0);
    send(1'b1, 32'h012A4020, 32'd3, 32'd4, 1'b0);
    check_eq("full_before_rst", in_ready, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_count", illegal_count, 8'd0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    q.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b1, 32'h012A4020, 32'd9, 32'd3, 1'b1);
    check_eq("post_rst_op", out_op, 4'b0000);
    check_eq("post_rst_a", out_a, 32'd9);
    check_eq("post_rst_b", out_b, 32'd3);

    // Randomized traffic, producer holds an unaccepted offer
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !last_in_fire)) begin
        in_valid  = ($urandom_range(0, 2) != 0);
        in_instr  = rand_instr();
        in_rs_val = $urandom;
        in_rt_val = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
